// File: rtl/gps_update_sched.sv
// gps_update_sched
// Once-per-second update scheduler for the speedometer pipeline.
// A synchronised 1PPS rising edge taken while the GPS reports a fix starts
// one transaction: pulse calc_start_o, wait for calc_done_i (bounded by a
// timeout), then hand the result to the display with a ready/load handshake.
// Missed PPS edges are counted. stale_o flags display data that is not
// current, either after too many bad seconds or when PPS edges stop.
module gps_update_sched #(
  parameter int CLK_HZ         = 12_000_000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int STALE_SECS     = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       onepps_i,
  input  logic       fix_i,
  output logic       calc_start_o,
  input  logic       calc_done_i,
  input  logic       disp_ready_i,
  output logic       disp_load_o,
  output logic       busy_o,
  output logic       timeout_o,
  output logic       stale_o,
  output logic [7:0] miss_cnt_o
);

  // Watchdog fires after STALE_SECS seconds without a PPS edge.
  localparam int WD_LIMIT = STALE_SECS * CLK_HZ;
  localparam int WD_W     = $clog2(WD_LIMIT) + 1;
  localparam int TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int BAD_W    = $clog2(STALE_SECS) + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_CALC = 2'd2,
    LOAD      = 2'd3
  } state_t;

  state_t             state_reg;
  logic [1:0]         pps_sync_reg;
  logic               pps_dly_reg;
  logic               pps_evt_reg;
  logic [WD_W-1:0]    wd_cnt_reg;
  logic [TMO_W-1:0]   tmo_cnt_reg;
  logic [BAD_W-1:0]   bad_secs_reg;
  logic [BAD_W-1:0]   bad_secs_inc;
  logic               stale_reg;
  logic               calc_start_reg;
  logic               timeout_reg;
  logic [7:0]         miss_cnt_reg;
  logic               wd_expire;

  // Two-flop synchroniser on the raw PPS, then a registered rising-edge
  // detect. pps_evt_reg is high for one cycle starting at the 3rd clk edge
  // after onepps_i rises.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pps_sync_reg <= 2'b00;
      pps_dly_reg  <= 1'b0;
      pps_evt_reg  <= 1'b0;
    end else begin
      pps_sync_reg <= {pps_sync_reg[0], onepps_i};
      pps_dly_reg  <= pps_sync_reg[1];
      pps_evt_reg  <= pps_sync_reg[1] & ~pps_dly_reg;
    end
  end

  // PPS watchdog: counts cycles since the last PPS event and parks at the
  // limit so it can never wrap back into a "fresh" range.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wd_cnt_reg <= '0;
    end else if (pps_evt_reg) begin
      wd_cnt_reg <= '0;
    end else if (wd_cnt_reg != WD_W'(WD_LIMIT)) begin
      wd_cnt_reg <= wd_cnt_reg + 1'b1;
    end
  end

  // Single-cycle event when the watchdog reaches its limit; a PPS arriving
  // on that same cycle restarts the count instead.
  assign wd_expire = !pps_evt_reg && (wd_cnt_reg == WD_W'(WD_LIMIT - 1));

  // Saturating increment of the bad-second counter.
  assign bad_secs_inc = (bad_secs_reg == BAD_W'(STALE_SECS)) ?
                        bad_secs_reg : bad_secs_reg + 1'b1;

  // Transaction FSM plus its bookkeeping: timeout counter, bad-second
  // counter, stale flag, miss counter and registered strobes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg      <= IDLE;
      tmo_cnt_reg    <= '0;
      bad_secs_reg   <= '0;
      stale_reg      <= 1'b1;
      calc_start_reg <= 1'b0;
      timeout_reg    <= 1'b0;
      miss_cnt_reg   <= 8'd0;
    end else begin
      calc_start_reg <= 1'b0;
      timeout_reg    <= 1'b0;

      // A PPS edge while a transaction is in flight is dropped and counted.
      if (pps_evt_reg && (state_reg != IDLE) && (miss_cnt_reg != 8'hFF)) begin
        miss_cnt_reg <= miss_cnt_reg + 8'd1;
      end

      // Watchdog sets stale; a completing LOAD below overrides it.
      if (wd_expire) begin
        stale_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (pps_evt_reg) begin
            if (fix_i) begin
              state_reg      <= START;
              calc_start_reg <= 1'b1;
            end else begin
              bad_secs_reg <= bad_secs_inc;
              if (bad_secs_inc == BAD_W'(STALE_SECS)) begin
                stale_reg <= 1'b1;
              end
            end
          end
        end

        START: begin
          state_reg   <= WAIT_CALC;
          tmo_cnt_reg <= '0;
        end

        WAIT_CALC: begin
          // Done is checked first so it wins over a same-cycle timeout.
          if (calc_done_i) begin
            state_reg <= LOAD;
          end else if (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_reg    <= IDLE;
            timeout_reg  <= 1'b1;
            bad_secs_reg <= bad_secs_inc;
            if (bad_secs_inc == BAD_W'(STALE_SECS)) begin
              stale_reg <= 1'b1;
            end
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end

        LOAD: begin
          // No timeout here: the display is allowed to stall indefinitely.
          if (disp_ready_i) begin
            state_reg    <= IDLE;
            bad_secs_reg <= '0;
            stale_reg    <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign calc_start_o = calc_start_reg;
  assign timeout_o    = timeout_reg;
  assign stale_o      = stale_reg;
  assign miss_cnt_o   = miss_cnt_reg;
  assign busy_o       = (state_reg != IDLE);
  // The load strobe is a same-cycle handshake with the display, so it is
  // qualified combinationally by disp_ready_i while the FSM sits in LOAD.
  assign disp_load_o  = (state_reg == LOAD) && disp_ready_i;

endmodule

// File: tb/tb_gps_update_sched.sv
// Testbench for gps_update_sched: table-driven single transaction plus
// hand-written sequences for timeout, missed edges, stale and reset cases.
module tb_gps_update_sched;

  logic       clk;
  logic       rst_n;
  logic       onepps;
  logic       fix;
  logic       calc_start;
  logic       calc_done;
  logic       disp_ready;
  logic       disp_load;
  logic       busy;
  logic       timeout;
  logic       stale;
  logic [7:0] miss_cnt;

  int checks   = 0;
  int failures = 0;

  gps_update_sched #(
    .CLK_HZ         (100),
    .TIMEOUT_CYCLES (20),
    .STALE_SECS     (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .onepps_i     (onepps),
    .fix_i        (fix),
    .calc_start_o (calc_start),
    .calc_done_i  (calc_done),
    .disp_ready_i (disp_ready),
    .disp_load_o  (disp_load),
    .busy_o       (busy),
    .timeout_o    (timeout),
    .stale_o      (stale),
    .miss_cnt_o   (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row: inputs applied before a clock edge, outputs expected after it.
  typedef struct packed {
    logic pps;
    logic fix;
    logic done;
    logic ready;
    logic e_start;
    logic e_load;
    logic e_busy;
    logic e_tmo;
    logic e_stale;
  } vec_t;

  vec_t vec [12];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Ten-cycle PPS period (high for 5, low for 5); reports which strobes
  // were seen at any point during the period.
  task automatic pps_period(output logic s_start, output logic s_load, output logic s_tmo);
    s_start = 1'b0;
    s_load  = 1'b0;
    s_tmo   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      onepps = (i < 5);
      tick;
      s_start = s_start | calc_start;
      s_load  = s_load | disp_load;
      s_tmo   = s_tmo | timeout;
    end
    onepps = 1'b0;
  endtask

  // PPS rise and the start pulse on the 4th edge after it.
  task automatic pps_to_start(input string tag);
    onepps = 1'b1;
    repeat (3) tick;
    chk1({tag, "_pre_start"}, calc_start, 1'b0);
    tick;
    chk1({tag, "_start"}, calc_start, 1'b1);
    chk1({tag, "_busy"}, busy, 1'b1);
    onepps = 1'b0;
  endtask

  // A calc wait that runs out; timeout pulses 20 cycles after WAIT_CALC entry.
  task automatic timeout_second(input string tag, input logic exp_stale);
    logic seen;
    pps_to_start(tag);
    seen = 1'b0;
    for (int e = 5; e <= 24; e++) begin
      tick;
      seen = seen | timeout | disp_load;
    end
    chk1({tag, "_early_tmo"}, seen, 1'b0);
    tick;
    chk1({tag, "_tmo"}, timeout, 1'b1);
    chk1({tag, "_idle"}, busy, 1'b0);
    chk1({tag, "_stale"}, stale, exp_stale);
    tick;
    chk1({tag, "_tmo_pulse"}, timeout, 1'b0);
    $display("txn %s: timeout second, stale=%b", tag, stale);
  endtask

  // Complete transaction: start at edge 4, done at edge 6, load, idle at edge 7.
  task automatic good_txn(input string tag);
    pps_to_start(tag);
    tick;
    calc_done = 1'b1;
    tick;
    chk1({tag, "_load"}, disp_load, 1'b1);
    calc_done = 1'b0;
    tick;
    chk1({tag, "_done_idle"}, busy, 1'b0);
    chk1({tag, "_stale_clr"}, stale, 1'b0);
    $display("txn %s: good update, stale=%b", tag, stale);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic s_start, s_load, s_tmo, seen;

    // inputs {pps,fix,done,ready} | expected {start,load,busy,tmo,stale}
    vec[0]  = 9'b1101_00001;
    vec[1]  = 9'b1101_00001;
    vec[2]  = 9'b1101_00001;
    vec[3]  = 9'b1101_10101;  // start 4 edges after the PPS rise
    vec[4]  = 9'b0101_00101;
    vec[5]  = 9'b0101_00101;
    vec[6]  = 9'b0101_00101;
    vec[7]  = 9'b0101_00101;
    vec[8]  = 9'b0111_01101;  // done 5 cycles after start -> load
    vec[9]  = 9'b0101_00000;  // load completed -> idle, stale clear
    vec[10] = 9'b0111_00000;  // done while idle is ignored
    vec[11] = 9'b0101_00000;

    rst_n      = 1'b0;
    onepps     = 1'b0;
    fix        = 1'b0;
    calc_done  = 1'b0;
    disp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk1("rst_start", calc_start, 1'b0);
    chk1("rst_load", disp_load, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_tmo", timeout, 1'b0);
    chk1("rst_stale", stale, 1'b1);
    chk8("rst_miss", miss_cnt, 8'd0);
    $display("txn reset: stale=%b miss=%0d", stale, miss_cnt);
    tick;

    // Basic transaction from the vector table.
    for (int i = 0; i < 12; i++) begin
      onepps     = vec[i].pps;
      fix        = vec[i].fix;
      calc_done  = vec[i].done;
      disp_ready = vec[i].ready;
      tick;
      chk1($sformatf("vec%0d_start", i), calc_start, vec[i].e_start);
      chk1($sformatf("vec%0d_load", i), disp_load, vec[i].e_load);
      chk1($sformatf("vec%0d_busy", i), busy, vec[i].e_busy);
      chk1($sformatf("vec%0d_tmo", i), timeout, vec[i].e_tmo);
      chk1($sformatf("vec%0d_stale", i), stale, vec[i].e_stale);
    end
    calc_done = 1'b0;
    $display("txn table: 12 rows applied");

    // Two timed-out seconds in a row make the data stale.
    timeout_second("tmo1", 1'b0);
    timeout_second("tmo2", 1'b1);

    // PPS every 10 cycles with done withheld: edges during WAIT_CALC are missed.
    pps_period(s_start, s_load, s_tmo);
    chk1("miss_p0_start", s_start, 1'b1);
    chk8("miss_p0_cnt", miss_cnt, 8'd0);
    pps_period(s_start, s_load, s_tmo);
    chk1("miss_p1_restart", s_start, 1'b0);
    chk8("miss_p1_cnt", miss_cnt, 8'd1);
    pps_period(s_start, s_load, s_tmo);
    chk8("miss_p2_cnt", miss_cnt, 8'd2);
    chk1("miss_p2_tmo", s_tmo, 1'b1);
    chk1("miss_p2_idle", busy, 1'b0);
    $display("txn miss: miss_cnt=%0d", miss_cnt);

    // Stall in LOAD with the display not ready, then hammer PPS edges.
    pps_to_start("hold");
    tick;
    calc_done  = 1'b1;
    disp_ready = 1'b0;
    tick;
    calc_done = 1'b0;
    chk1("hold_load_lo", disp_load, 1'b0);
    chk1("hold_busy", busy, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick;
      seen = seen | timeout | disp_load | ~busy;
    end
    chk1("hold_50_no_tmo", seen, 1'b0);
    for (int p = 1; p <= 300; p++) begin
      pps_period(s_start, s_load, s_tmo);
      seen = seen | s_start | s_load | s_tmo;
      if (p == 252) chk8("sat_252", miss_cnt, 8'd254);
      if (p == 253) chk8("sat_253", miss_cnt, 8'd255);
    end
    chk8("sat_300", miss_cnt, 8'd255);
    chk1("sat_no_strobes", seen, 1'b0);
    chk1("sat_still_load", busy, 1'b1);
    disp_ready = 1'b1;
    #1;
    chk1("hold_release_load", disp_load, 1'b1);
    tick;
    chk1("hold_release_idle", busy, 1'b0);
    chk1("hold_release_stale", stale, 1'b0);
    $display("txn hold: miss_cnt=%0d stale=%b", miss_cnt, stale);

    // Done on the timeout-limit cycle wins; fix drop mid-transaction is harmless.
    pps_to_start("race");
    fix = 1'b0;
    tick;
    repeat (19) tick;
    calc_done = 1'b1;
    tick;
    chk1("race_no_tmo", timeout, 1'b0);
    chk1("race_load", disp_load, 1'b1);
    calc_done = 1'b0;
    tick;
    chk1("race_idle", busy, 1'b0);
    chk1("race_tmo_after", timeout, 1'b0);
    chk1("race_stale", stale, 1'b0);
    $display("txn race: done beat timeout");

    // No fix for two seconds: no start, stale after the second.
    fix = 1'b0;
    pps_period(s_start, s_load, s_tmo);
    chk1("nofix1_start", s_start, 1'b0);
    chk1("nofix1_stale", stale, 1'b0);
    pps_period(s_start, s_load, s_tmo);
    chk1("nofix2_start", s_start, 1'b0);
    chk1("nofix2_stale", stale, 1'b1);
    fix = 1'b1;
    good_txn("refix");

    // Watchdog: stale exactly 200 cycles after the PPS event was taken.
    repeat (196) tick;
    chk1("wd_199", stale, 1'b0);
    tick;
    chk1("wd_200", stale, 1'b1);
    repeat (20) tick;
    chk1("wd_hold", stale, 1'b1);
    $display("txn watchdog: stale=%b", stale);

    // Reset in the middle of WAIT_CALC.
    pps_to_start("rst");
    repeat (3) tick;
    rst_n = 1'b0;
    #1;
    chk1("rst_mid_busy", busy, 1'b0);
    chk1("rst_mid_stale", stale, 1'b1);
    chk8("rst_mid_miss", miss_cnt, 8'd0);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick;
      seen = seen | calc_start | disp_load | timeout | busy;
    end
    chk1("rst_mid_quiet", seen, 1'b0);
    $display("txn reset_mid: quiet after release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
